// File: rtl/designparameters.sv
// Shared constants, FSM state type and helpers for the I2C slave memory.
package designparameters;

    localparam logic [6:0] SLAVE_ADDR   = 7'h50;
    localparam logic       I2C_RW_WRITE = 1'b0;
    localparam logic       I2C_RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        DEVACK,
        PTR,
        PTRACK,
        WRDATA,
        WRACK,
        RDDATA,
        RDACK,
        WAITSTOP
    } i2c_state_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_slave_mem_if.sv
// I2C pin bundle: sampled SCL/SDA inputs and the open-drain SDA pull-down.
interface i2c_slave_mem_if;

    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport slave  (input scl_i, input sda_i, output sda_oe);
    modport master (output scl_i, output sda_i, input sda_oe);

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers, optional 3-sample majority filter (I2C_SLV_GLITCH_FILTER_EN),
// and SCL edge / START / STOP detection on the clean copies.
module i2c_bus_sync
    import designparameters::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_d;
    logic       r_sda_d;
    logic       w_scl;
    logic       w_sda;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [2:0] r_scl_hist;
    logic [2:0] r_sda_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_hist <= 3'b111;
            r_sda_hist <= 3'b111;
        end else begin
            r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
        end
    end

    // A single-clk excursion never wins the vote
    assign w_scl = maj3(r_scl_hist);
    assign w_sda = maj3(r_sda_hist);
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C slave exposing a 2**ADDR_W byte memory with an auto-incrementing pointer.
// Build option: I2C_SLV_GLITCH_FILTER_EN enables the SCL/SDA majority filter.
module i2c_slave_mem
    import designparameters::*;
#(
    parameter int         ADDR_W   = 7,
    parameter logic [6:0] DEV_ADDR = SLAVE_ADDR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_slave_mem_if.slave        bus,
    output logic                  busy,
    output logic                  wr_stb,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            wr_data
);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (bus.scl_i),
        .i_sda      (bus.sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_state_t          r_state, w_state_nxt;
    logic [3:0]          r_bitcnt, w_bitcnt_nxt;
    logic [7:0]          r_shift, w_shift_nxt;
    logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
    logic                r_sda_oe, w_sda_oe_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_rw, w_rw_nxt;
    logic                r_wr_stb;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [7:0]          r_wr_data;
    logic                w_wr_en;
    logic [7:0]          w_byte;
    logic [7:0]          w_rd_byte;
    logic [7:0]          r_mem [0:(1<<ADDR_W)-1];

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_rd_byte = r_mem[r_ptr];

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_ptr_nxt    = r_ptr;
        w_sda_oe_nxt = r_sda_oe;
        w_busy_nxt   = r_busy;
        w_rw_nxt     = r_rw;
        w_wr_en      = 1'b0;
        if (w_stop) begin
            w_state_nxt  = IDLE;
            w_bitcnt_nxt = '0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = DEVADDR;
            w_bitcnt_nxt = '0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                DEVADDR, PTR, WRDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_byte;
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            w_bitcnt_nxt = '0;
                            if (r_state == DEVADDR) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    w_state_nxt = DEVACK;
                                    w_rw_nxt    = w_byte[0];
                                    w_busy_nxt  = 1'b1;
                                end else begin
                                    w_state_nxt = WAITSTOP;
                                end
                            end else if (r_state == PTR) begin
                                w_ptr_nxt   = w_byte[ADDR_W-1:0];
                                w_state_nxt = PTRACK;
                            end else begin
                                w_wr_en     = 1'b1;
                                w_ptr_nxt   = r_ptr + ADDR_W'(1);
                                w_state_nxt = WRACK;
                            end
                        end
                    end
                end
                // First SCL fall asserts the ACK, the next one ends the 9th period
                DEVACK, PTRACK, WRACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_bitcnt_nxt = '0;
                            if (r_state == DEVACK && r_rw == I2C_RW_READ) begin
                                w_state_nxt  = RDDATA;
                                w_shift_nxt  = w_rd_byte;
                                w_sda_oe_nxt = ~w_rd_byte[7];
                            end else if (r_state == DEVACK && r_rw == I2C_RW_WRITE) begin
                                w_state_nxt = PTR;
                            end else begin
                                w_state_nxt = WRDATA;
                            end
                        end
                    end
                end
                RDDATA: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_sda_oe_nxt = 1'b0;
                            w_bitcnt_nxt = '0;
                            w_ptr_nxt    = r_ptr + ADDR_W'(1);
                            w_state_nxt  = RDACK;
                        end else begin
                            w_sda_oe_nxt = ~r_shift[3'd7 - r_bitcnt[2:0]];
                        end
                    end
                end
                RDACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda) begin
                            w_state_nxt  = RDDATA;
                            w_shift_nxt  = w_rd_byte;
                            w_bitcnt_nxt = '0;
                        end else begin
                            w_state_nxt = WAITSTOP;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_rw      <= w_rw_nxt;
            r_wr_stb  <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte;
            end
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_ptr] <= w_byte;
    end

    assign bus.sda_oe = r_sda_oe;
    assign busy       = r_busy;
    assign wr_stb     = r_wr_stb;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: bit-banged I2C master with hand-computed expectations.
module tb_i2c_slave_mem;
    import designparameters::*;

    localparam int Q = 100;

    logic       clk;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    logic       busy;
    logic       wr_stb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_cnt  = 0;
    int start_cnt = 0;
    logic [6:0] last_addr = '0;
    logic [7:0] last_data = '0;

    i2c_slave_mem_if bif ();

    assign bif.scl_i = m_scl;
    assign bif.sda_i = m_sda & ~bif.sda_oe;

    i2c_slave_mem #(.ADDR_W(7), .DEV_ADDR(7'h50)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bif),
        .busy    (busy),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (wr_stb) begin
            stb_cnt   <= stb_cnt + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
        if (dut.w_start) start_cnt <= start_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #Q;
        m_scl = 1'b1; #(2*Q);
        m_scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        ack = ~bif.sda_i; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; #Q;
            m_scl = 1'b1; #Q;
            d[i] = bif.sda_i; #Q;
            m_scl = 1'b0; #Q;
        end
        m_sda = ~mack; #Q;
        m_scl = 1'b1; #(2*Q);
        m_scl = 1'b0; #Q;
    endtask

    task automatic test_reset();
        n_checks++; if (bif.sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got=%b exp=0", bif.sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL reset_wr_stb got=%b exp=0", wr_stb); end
        n_checks++; if (wr_addr !== 7'h00 || wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_bus got=%h/%h exp=00/00", wr_addr, wr_data); end
        n_checks++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, IDLE); end
        n_checks++; if (dut.r_ptr !== 7'h00) begin n_fail++; $display("FAIL reset_ptr got=%h exp=00", dut.r_ptr); end
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        int s0;
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy got=%b exp=1", busy); end
        send_byte(8'h10, a1);
        send_byte(8'h5A, a2);
        n_checks++; if (last_addr !== 7'h10 || last_data !== 8'h5A) begin n_fail++; $display("FAIL wr_first got=%h/%h exp=10/5a", last_addr, last_data); end
        send_byte(8'h3C, a3);
        n_checks++; if (last_addr !== 7'h11 || last_data !== 8'h3C) begin n_fail++; $display("FAIL wr_second got=%h/%h exp=11/3c", last_addr, last_data); end
        i2c_stop();
        n_checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_fail++; $display("FAIL wr_acks got=%b exp=1111", {a0, a1, a2, a3}); end
        n_checks++; if (stb_cnt - s0 !== 2) begin n_fail++; $display("FAIL wr_stb_count got=%0d exp=2", stb_cnt - s0); end
        n_checks++; if (dut.r_mem[16] !== 8'h5A || dut.r_mem[17] !== 8'h3C) begin n_fail++; $display("FAIL wr_mem got=%h/%h exp=5a/3c", dut.r_mem[16], dut.r_mem[17]); end
        n_checks++; if (busy !== 1'b0 || dut.r_state !== IDLE) begin n_fail++; $display("FAIL wr_after_stop got busy=%b state=%0d exp busy=0 state=%0d", busy, dut.r_state, IDLE); end
    endtask

    task automatic test_random_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h10, a1);
        i2c_start();
        send_byte(8'hA1, a2);
        recv_byte(1'b1, d0);
        recv_byte(1'b0, d1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_after_nack got=%b exp=0", busy); end
        i2c_stop();
        n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rd_acks got=%b exp=111", {a0, a1, a2}); end
        n_checks++; if (d0 !== 8'h5A) begin n_fail++; $display("FAIL rd_byte0 got=%h exp=5a", d0); end
        n_checks++; if (d1 !== 8'h3C) begin n_fail++; $display("FAIL rd_byte1 got=%h exp=3c", d1); end
        n_checks++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL rd_state got=%0d exp=%0d", dut.r_state, IDLE); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1, a2;
        int s0;
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'hA2, a0);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wa_busy got=%b exp=0", busy); end
        send_byte(8'h10, a1);
        send_byte(8'hEE, a2);
        i2c_stop();
        n_checks++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL wa_acks got=%b exp=000", {a0, a1, a2}); end
        n_checks++; if (stb_cnt - s0 !== 0) begin n_fail++; $display("FAIL wa_stb_count got=%0d exp=0", stb_cnt - s0); end
        n_checks++; if (dut.r_mem[16] !== 8'h5A) begin n_fail++; $display("FAIL wa_mem got=%h exp=5a", dut.r_mem[16]); end
        n_checks++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL wa_state got=%0d exp=%0d", dut.r_state, IDLE); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3, a4, a5, a6;
        logic [7:0] d0, d1;
        int s0;
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h7F, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        i2c_stop();
        n_checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_fail++; $display("FAIL wrap_acks got=%b exp=1111", {a0, a1, a2, a3}); end
        n_checks++; if (dut.r_mem[127] !== 8'h11 || dut.r_mem[0] !== 8'h22) begin n_fail++; $display("FAIL wrap_mem got=%h/%h exp=11/22", dut.r_mem[127], dut.r_mem[0]); end
        n_checks++; if (stb_cnt - s0 !== 2 || last_addr !== 7'h00) begin n_fail++; $display("FAIL wrap_stb got=%0d@%h exp=2@00", stb_cnt - s0, last_addr); end
        n_checks++; if (dut.r_ptr !== 7'h01) begin n_fail++; $display("FAIL wrap_ptr got=%h exp=01", dut.r_ptr); end
        // Pointer-only write, then a current-address read across the wrap
        i2c_start();
        send_byte(8'hA0, a4);
        send_byte(8'h7F, a5);
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, a6);
        recv_byte(1'b1, d0);
        recv_byte(1'b0, d1);
        i2c_stop();
        n_checks++; if ({a4, a5, a6} !== 3'b111) begin n_fail++; $display("FAIL cur_acks got=%b exp=111", {a4, a5, a6}); end
        n_checks++; if (d0 !== 8'h11 || d1 !== 8'h22) begin n_fail++; $display("FAIL cur_read got=%h/%h exp=11/22", d0, d1); end
        n_checks++; if (dut.r_ptr !== 7'h01) begin n_fail++; $display("FAIL cur_ptr got=%h exp=01", dut.r_ptr); end
    endtask

    task automatic test_partial_stop();
        logic a0, a1;
        int s0;
        s0 = stb_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h10, a1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        i2c_stop();
        n_checks++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL part_acks got=%b exp=11", {a0, a1}); end
        n_checks++; if (stb_cnt - s0 !== 0) begin n_fail++; $display("FAIL part_stb_count got=%0d exp=0", stb_cnt - s0); end
        n_checks++; if (dut.r_state !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL part_state got=%0d busy=%b exp=%0d busy=0", dut.r_state, busy, IDLE); end
        n_checks++; if (dut.r_mem[16] !== 8'h5A) begin n_fail++; $display("FAIL part_mem got=%h exp=5a", dut.r_mem[16]); end
    endtask

    task automatic test_reset_mid_read();
        logic a0;
        i2c_start();
        send_byte(8'hA1, a0);
        // mem[0x10] = 0x5A, so the slave pulls SDA low for the MSB
        m_sda = 1'b1; #Q;
        n_checks++; if (a0 !== 1'b1 || bif.sda_oe !== 1'b1) begin n_fail++; $display("FAIL rmr_driving got ack=%b oe=%b exp ack=1 oe=1", a0, bif.sda_oe); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bif.sda_oe !== 1'b0) begin n_fail++; $display("FAIL rmr_sda_release got=%b exp=0", bif.sda_oe); end
        @(posedge clk); #1;
        n_checks++; if (dut.r_ptr !== 7'h00 || dut.r_state !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL rmr_state got ptr=%h state=%0d busy=%b exp ptr=00 state=%0d busy=0", dut.r_ptr, dut.r_state, busy, IDLE); end
        m_scl = 1'b1;
        m_sda = 1'b1;
        #Q;
        rst_n = 1'b1;
        #Q;
        n_checks++; if (dut.r_mem[16] !== 8'h5A) begin n_fail++; $display("FAIL rmr_mem_kept got=%h exp=5a", dut.r_mem[16]); end
    endtask

    task automatic test_glitch();
        int c0;
        int exp_starts;
`ifdef I2C_SLV_GLITCH_FILTER_EN
        exp_starts = 0;
`else
        exp_starts = 1;
`endif
        c0 = start_cnt;
        @(negedge clk);
        m_sda = 1'b0;
        @(negedge clk);
        m_sda = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (start_cnt - c0 !== exp_starts) begin n_fail++; $display("FAIL glitch_start got=%0d exp=%0d", start_cnt - c0, exp_starts); end
        n_checks++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL glitch_state got=%0d exp=%0d", dut.r_state, IDLE); end
    endtask

    initial begin
        rst_n = 1'b0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        rst_n = 1'b1;
        #Q;
        test_write();
        test_random_read();
        test_wrong_addr();
        test_wrap();
        test_partial_stop();
        test_reset_mid_read();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_mem.md
I2C_SLAVE_MEM -- requirements
Module: i2c_slave_mem

Interface
REQ-001 Parameter ADDR_W, default 7: memory pointer width; depth = 2**ADDR_W bytes.
REQ-002 Parameter DEV_ADDR, default SLAVE_ADDR from designparameters: 7-bit I2C device address.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 scl_i  in  1  I2C clock pin, asynchronous to clk.
REQ-006 sda_i  in  1  I2C data pin, asynchronous to clk.
REQ-007 sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 busy  out  1  high from matched address ACK until STOP, START or NACK-exit.
REQ-009 wr_stb  out  1  one-clk pulse per byte written to memory.
REQ-010 wr_addr  out  ADDR_W  address of the write flagged by wr_stb.
REQ-011 wr_data  out  8  data of the write flagged by wr_stb.

Function
REQ-012 scl_i/sda_i SHALL pass through 2-flop synchronisers; edges detected on synchronised copies.
REQ-013 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while SCL high.
REQ-014 SDA SHALL be sampled on SCL rising edge, MSB first; sda_oe SHALL change only one clk after a detected SCL falling edge.
REQ-015 States: IDLE, DEVADDR, DEVACK, PTR, PTRACK, WRDATA, WRACK, RDDATA, RDACK, WAITSTOP.
REQ-016 START in any state -> DEVADDR, bit counter cleared (repeated START supported); STOP in any state -> IDLE, sda_oe=0.
REQ-017 DEVADDR: after 8 bits, upper 7 = DEV_ADDR -> DEVACK (sda_oe=1 for the 9th SCL period); mismatch -> WAITSTOP, no ACK.
REQ-018 DEVACK with R/W=0 -> PTR; R/W=1 -> RDDATA, first read byte = mem[ptr].
REQ-019 PTR: low ADDR_W bits of received byte load ptr; upper bits ignored; ACK, then WRDATA.
REQ-020 WRDATA: each complete byte written to mem[ptr] on the 8th SCL rise, wr_stb pulses, ptr increments, ACK issued.
REQ-021 RDDATA: slave drives sda_oe = ~bit (MSB first) over 8 SCL periods, releases SDA for 9th; ptr increments after byte.
REQ-022 RDACK: master ACK (SDA low) -> next byte; master NACK -> WAITSTOP.
REQ-023 ptr SHALL wrap from 2**ADDR_W-1 to 0 on increment in both read and write.
REQ-024 START or STOP mid-byte SHALL discard the partial byte; no memory write, no wr_stb.
REQ-025 ptr SHALL persist across transactions (current-address read supported).

Reset
REQ-026 rst_n low: state=IDLE, ptr=0, bit counter=0, sda_oe=0, busy=0, wr_stb=0, wr_addr=0, wr_data=0, synchronisers=1.
REQ-027 Memory contents SHALL not be reset; reset asserted mid-transaction releases SDA immediately.

Configuration
REQ-028 I2C_SLV_GLITCH_FILTER_EN defined: after synchronisers, SCL/SDA each pass a 3-sample majority filter (adds 2 clk latency); pulses of 1 clk ignored.
REQ-029 Macro undefined: no filter; synchronised signals used directly; a 1-clk SCL pulse is a valid edge.

Structure
REQ-030 designparameters SHALL hold SLAVE_ADDR, the state enum typedef and the I2C_RW_WRITE/I2C_RW_READ constants.
REQ-031 One sub-module i2c_bus_sync (synchroniser, optional filter, START/STOP/edge detect); FSM and memory in i2c_slave_mem.

Verification
REQ-032 Write: START, 0xA0, ptr 0x10, data 0x5A, 0x3C, STOP -> ACK x4, mem[0x10]=0x5A, mem[0x11]=0x3C, two wr_stb pulses.
REQ-033 Random read: START, 0xA0, ptr 0x10, repeated START, 0xA1, master ACK then NACK -> returns 0x5A, 0x3C; then IDLE.
REQ-034 Wrong address 0xA2 -> no ACK (sda_oe stays 0), busy=0, memory unchanged until STOP.
REQ-035 Write ptr 0x7F, data 0x11, 0x22 -> mem[0x7F]=0x11, mem[0x00]=0x22 (wrap).
REQ-036 STOP after 4 data bits -> no wr_stb, state IDLE; rst_n low mid-read -> sda_oe=0 within 1 clk, ptr=0.
REQ-037 With I2C_SLV_GLITCH_FILTER_EN, 1-clk SDA low pulse while SCL high -> no START detected.
